// File: rtl/persiana_planta_if.sv
// Motor-command / sensor bundle between the blind controller (master) and the plant model (slave).
interface persiana_planta_if #(
    parameter int POS_W = 8
);
    logic             subir;
    logic             bajar;
    logic             Ssup;
    logic             Smed;
    logic             Sinf;
    logic [POS_W-1:0] pos;
    logic             moving;
    logic             fault;

    modport master (
        output subir, bajar,
        input  Ssup, Smed, Sinf, pos, moving, fault
    );

    modport slave (
        input  subir, bajar,
        output Ssup, Smed, Sinf, pos, moving, fault
    );
endinterface

// File: rtl/persiana_planta.sv
// Behavioural plant of the motorised blind: integrates motor commands into a position and
// decodes limit/middle sensors, with travel limits, reversal dead-time and a conflict fault.
module persiana_planta #(
    parameter int POS_W    = 8,
    parameter int POS_MAX  = 200,
    parameter int POS_MID  = 100,
    parameter int MED_TOL  = 2,
    parameter int STEP_DIV = 4,
    parameter int DEADTIME = 3,
    parameter int POS_RST  = 0
) (
    input  logic              clk,
    input  logic              reseteo,
    persiana_planta_if.slave  bus
);
    localparam int STP_W = $clog2(STEP_DIV) + 1;
    localparam int DC_W  = $clog2(DEADTIME) + 1;

    localparam logic [POS_W-1:0] P_MAX    = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] P_RST    = POS_W'(POS_RST);
    localparam logic [POS_W-1:0] P_MED_LO = POS_W'(POS_MID - MED_TOL);
    localparam logic [POS_W-1:0] P_MED_HI = POS_W'(POS_MID + MED_TOL);
    localparam logic [STP_W-1:0] STP_LAST = STP_W'(STEP_DIV - 1);
    localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(DEADTIME - 1);

    typedef enum logic [2:0] {IDLE, UP, DOWN, DEAD, FAULT} state_t;

    state_t           r_state, w_state_nx;
    logic [POS_W-1:0] r_pos, w_pos_nx;
    logic [STP_W-1:0] r_stp, w_stp_nx;
    logic [DC_W-1:0]  r_dc, w_dc_nx;
    logic             w_both;

    assign w_both = bus.subir & bus.bajar;

    always_ff @(posedge clk or posedge reseteo) begin
        if (reseteo) begin
            r_state <= IDLE;
            r_pos   <= P_RST;
            r_stp   <= '0;
            r_dc    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_pos   <= w_pos_nx;
            r_stp   <= w_stp_nx;
            r_dc    <= w_dc_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_pos_nx   = r_pos;
        w_stp_nx   = r_stp;
        w_dc_nx    = r_dc;
        unique case (r_state)
            IDLE: begin
                if (w_both) begin
                    w_state_nx = FAULT;
                    w_stp_nx   = '0;
                    w_dc_nx    = '0;
                end else if (bus.subir && (r_pos < P_MAX)) begin
                    w_state_nx = UP;
                end else if (bus.bajar && (r_pos != '0)) begin
                    w_state_nx = DOWN;
                end
            end
            UP: begin
                // Dropping the command discards the partial step.
                if (w_both) begin
                    w_state_nx = FAULT;
                    w_stp_nx   = '0;
                    w_dc_nx    = '0;
                end else if (!bus.subir) begin
                    w_state_nx = DEAD;
                    w_stp_nx   = '0;
                end else if (r_stp == STP_LAST) begin
                    w_pos_nx = r_pos + 1'b1;
                    w_stp_nx = '0;
                    if (r_pos == P_MAX - 1'b1) w_state_nx = DEAD;
                end else begin
                    w_stp_nx = r_stp + 1'b1;
                end
            end
            DOWN: begin
                if (w_both) begin
                    w_state_nx = FAULT;
                    w_stp_nx   = '0;
                    w_dc_nx    = '0;
                end else if (!bus.bajar) begin
                    w_state_nx = DEAD;
                    w_stp_nx   = '0;
                end else if (r_stp == STP_LAST) begin
                    w_pos_nx = r_pos - 1'b1;
                    w_stp_nx = '0;
                    if (r_pos == POS_W'(1)) w_state_nx = DEAD;
                end else begin
                    w_stp_nx = r_stp + 1'b1;
                end
            end
            DEAD: begin
                if (w_both) begin
                    w_state_nx = FAULT;
                    w_stp_nx   = '0;
                    w_dc_nx    = '0;
                end else if (r_dc == DC_LAST) begin
                    w_state_nx = IDLE;
                    w_dc_nx    = '0;
                end else begin
                    w_dc_nx = r_dc + 1'b1;
                end
            end
            FAULT: begin
                // Leave only once both commands are released.
                if (!bus.subir && !bus.bajar) begin
                    w_state_nx = DEAD;
                    w_stp_nx   = '0;
                    w_dc_nx    = '0;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_stp_nx   = '0;
                w_dc_nx    = '0;
            end
        endcase
    end

    assign bus.pos    = r_pos;
    assign bus.Ssup   = (r_pos == P_MAX);
    assign bus.Sinf   = (r_pos == '0);
    assign bus.Smed   = (r_pos >= P_MED_LO) && (r_pos <= P_MED_HI);
    assign bus.moving = (r_state == UP) || (r_state == DOWN);
    assign bus.fault  = (r_state == FAULT);
endmodule

// File: tb/tb_persiana_planta.sv
// Directed scenarios plus randomized command bursts, compared every cycle with a position/timer model.
module tb_persiana_planta;
    localparam int POS_W    = 8;
    localparam int POS_MAX  = 200;
    localparam int POS_MID  = 100;
    localparam int MED_TOL  = 2;
    localparam int STEP_DIV = 4;
    localparam int DEADTIME = 3;
    localparam int POS_RST  = 0;

    logic clk = 1'b0;
    logic reseteo = 1'b0;
    always #5 clk = ~clk;

    persiana_planta_if #(.POS_W(POS_W)) bif ();

    persiana_planta #(
        .POS_W(POS_W), .POS_MAX(POS_MAX), .POS_MID(POS_MID), .MED_TOL(MED_TOL),
        .STEP_DIV(STEP_DIV), .DEADTIME(DEADTIME), .POS_RST(POS_RST)
    ) dut (
        .clk(clk),
        .reseteo(reseteo),
        .bus(bif)
    );

    int checks = 0;
    int failures = 0;

    // Model: position, travel direction, cycles into current step, remaining blocked cycles, fault flag.
    int m_pos, m_dir, m_cnt, m_dead;
    bit m_fault;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = POS_RST; m_dir = 0; m_cnt = 0; m_dead = 0; m_fault = 0;
    endtask

    task automatic model_edge(input bit s, input bit b);
        if (m_fault) begin
            if (!s && !b) begin m_fault = 0; m_dead = DEADTIME; end
        end else if (s && b) begin
            m_fault = 1; m_dir = 0; m_cnt = 0; m_dead = 0;
        end else if (m_dead > 0) begin
            m_dead--;
        end else if (m_dir == 0) begin
            if (s && m_pos < POS_MAX) begin m_dir = 1; m_cnt = 0; end
            else if (b && m_pos > 0) begin m_dir = -1; m_cnt = 0; end
        end else if ((m_dir > 0 && !s) || (m_dir < 0 && !b)) begin
            m_dir = 0; m_cnt = 0; m_dead = DEADTIME;
        end else begin
            m_cnt++;
            if (m_cnt == STEP_DIV) begin
                m_cnt = 0;
                m_pos += m_dir;
                if (m_pos == POS_MAX || m_pos == 0) begin m_dir = 0; m_dead = DEADTIME; end
            end
        end
    endtask

    task automatic chk_all();
        chk("pos",    bif.pos,    m_pos);
        chk("Ssup",   bif.Ssup,   (m_pos == POS_MAX));
        chk("Sinf",   bif.Sinf,   (m_pos == 0));
        chk("Smed",   bif.Smed,   (m_pos >= POS_MID - MED_TOL) && (m_pos <= POS_MID + MED_TOL));
        chk("moving", bif.moving, (m_dir != 0));
        chk("fault",  bif.fault,  m_fault);
    endtask

    task automatic step(input bit s, input bit b);
        bif.subir = s;
        bif.bajar = b;
        @(posedge clk);
        model_edge(s, b);
        #1;
        chk_all();
    endtask

    initial begin
        int n;
        int cmd;
        int len;
        bif.subir = 1'b0;
        bif.bajar = 1'b0;
        model_reset();
        #1 reseteo = 1'b1;
        #2;
        chk("rst_pos", bif.pos, 0);
        chk("rst_Sinf", bif.Sinf, 1);
        chk_all();
        @(negedge clk) reseteo = 1'b0;

        // Up from 0: first step lands STEP_DIV cycles after entry.
        step(1, 0);
        chk("enter_up", bif.moving, 1);
        repeat (STEP_DIV) step(1, 0);
        chk("first_step", bif.pos, 1);
        for (int i = 0; i < 1000 && m_pos != 30; i++) step(1, 0);

        // Conflicting command at pos 30.
        step(1, 1);
        chk("fault_set", bif.fault, 1);
        chk("fault_pos", bif.pos, 30);
        step(1, 0);
        chk("fault_sticky", bif.fault, 1);
        step(0, 0);
        chk("fault_clear", bif.fault, 0);
        step(1, 0);
        step(1, 0);
        chk("fault_dead", bif.moving, 0);
        step(1, 0);
        chk("dead_to_idle", bif.moving, 0);
        step(1, 0);
        chk("idle_accept", bif.moving, 1);

        // Reversal at pos 50.
        for (int i = 0; i < 1000 && m_pos != 50; i++) step(1, 0);
        repeat (DEADTIME + 1) begin
            step(0, 1);
            chk("rev_dead_mv", bif.moving, 0);
            chk("rev_dead_pos", bif.pos, 50);
        end
        step(0, 1);
        chk("rev_down", bif.moving, 1);
        repeat (STEP_DIV) step(0, 1);
        chk("rev_pos49", bif.pos, 49);

        // Down to the bottom limit, then a command toward it is ignored.
        for (int i = 0; i < 1000 && m_pos != 0; i++) step(0, 1);
        repeat (DEADTIME + 4) step(0, 1);
        chk("bottom_idle", bif.moving, 0);
        chk("bottom_Sinf", bif.Sinf, 1);

        // Full travel 0 -> POS_MAX.
        step(1, 0);
        n = 0;
        while (!bif.Ssup && n < 1000) begin step(1, 0); n++; end
        chk("full_travel", n, POS_MAX * STEP_DIV);
        chk("top_moving", bif.moving, 0);
        repeat (DEADTIME + 4) step(1, 0);
        chk("top_pos", bif.pos, POS_MAX);
        chk("top_idle", bif.moving, 0);

        // Async reset mid-step at pos 120 while travelling down.
        for (int i = 0; i < 2000 && m_pos != 120; i++) step(0, 1);
        step(0, 1);
        step(0, 1);
        #2 reseteo = 1'b1;
        #1;
        chk("async_pos", bif.pos, 0);
        chk("async_moving", bif.moving, 0);
        chk("async_fault", bif.fault, 0);
        model_reset();
        chk_all();
        #2 reseteo = 1'b0;
        step(1, 0);
        chk("post_rst_up", bif.moving, 1);

        // Randomized command bursts.
        n = 0;
        while (n < 1500) begin
            cmd = $urandom_range(0, 19);
            len = $urandom_range(1, 40);
            repeat (len) begin
                if (cmd == 0)      step(1, 1);
                else if (cmd < 9)  step(1, 0);
                else if (cmd < 17) step(0, 1);
                else               step(0, 0);
                n++;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
